// File: rtl/vc_buf_pkg.sv
// Width helpers shared by the virtual-channel buffer pool and its free list.
package vc_buf_pkg;

    function automatic int unsigned clog2_min1(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int unsigned vc_w(input int unsigned num_vc);
        return clog2_min1(num_vc);
    endfunction

    function automatic int unsigned ptr_w(input int unsigned depth);
        return clog2_min1(depth);
    endfunction

    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vc_free_list.sv
// Free-entry bitmask for the shared pool: lowest-index grant, alloc/release, free count.
module vc_free_list
    import vc_buf_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        alloc,
    input  logic                        rel,
    input  logic [ptr_w(DEPTH)-1:0]     rel_idx,
    output logic [ptr_w(DEPTH)-1:0]     grant_idx,
    output logic [cnt_w(DEPTH)-1:0]     free_count
);

    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    logic [DEPTH-1:0] mask_q;
    logic [DEPTH-1:0] mask_d;
    logic             found;

    // Grant and count come from the registered mask, so a released entry
    // only becomes grantable from the cycle after its release.
    always_comb begin
        grant_idx  = '0;
        found      = 1'b0;
        free_count = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (mask_q[i] && !found) begin
                grant_idx = PTR_W'(i);
                found     = 1'b1;
            end
            free_count = free_count + CNT_W'(mask_q[i]);
        end
    end

    always_comb begin
        mask_d = mask_q;
        if (alloc) mask_d[grant_idx] = 1'b0;
        if (rel)   mask_d[rel_idx]   = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mask_q <= '1;
        else        mask_q <= mask_d;
    end

endmodule

// File: rtl/vc_shared_buf_pool.sv
// NUM_VC linked-list FIFOs sharing one DEPTH-entry data pool.
// Optional VC_RESERVE_EN: each empty VC keeps one pool slot in reserve.
module vc_shared_buf_pool
    import vc_buf_pkg::*;
#(
    parameter int NUM_VC = 4,
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              enq_valid,
    input  logic [vc_w(NUM_VC)-1:0]           enq_vc,
    input  logic [DATA_W-1:0]                 enq_data,
    output logic                              enq_ready,
    input  logic [vc_w(NUM_VC)-1:0]           deq_vc,
    input  logic                              deq_ready,
    output logic                              deq_valid,
    output logic [DATA_W-1:0]                 deq_data,
    output logic [NUM_VC*cnt_w(DEPTH)-1:0]    vc_count,
    output logic [cnt_w(DEPTH)-1:0]           free_count
);

    localparam int VC_W  = vc_w(NUM_VC);
    localparam int PTR_W = ptr_w(DEPTH);
    localparam int CNT_W = cnt_w(DEPTH);

    typedef struct packed {
        logic [PTR_W-1:0] head;
        logic [PTR_W-1:0] tail;
        logic [CNT_W-1:0] count;
    } vc_state_t;

    typedef logic [DATA_W-1:0] entry_t;

    vc_state_t        vc_q    [NUM_VC];
    vc_state_t        vc_d    [NUM_VC];
    logic [PTR_W-1:0] next_q  [DEPTH];
    entry_t           pool_q  [DEPTH];

    logic [PTR_W-1:0] grant_idx;
    logic [PTR_W-1:0] deq_head;
    logic [PTR_W-1:0] next_wa;
    logic [VC_W-1:0]  enq_sel;
    logic [VC_W-1:0]  deq_sel;
    logic             enq_ok, deq_ok, rsv_ok;
    logic             enq_fire, deq_fire, next_we;

    generate
        if ((1 << VC_W) == NUM_VC) begin : g_vc_pow2
            assign enq_ok = 1'b1;
            assign deq_ok = 1'b1;
        end else begin : g_vc_range
            assign enq_ok = int'(enq_vc) < NUM_VC;
            assign deq_ok = int'(deq_vc) < NUM_VC;
        end
    endgenerate

    assign enq_sel   = enq_ok ? enq_vc : '0;
    assign deq_sel   = deq_ok ? deq_vc : '0;
    assign deq_head  = vc_q[deq_sel].head;
    assign deq_valid = deq_ok && (vc_q[deq_sel].count != '0);
    assign deq_data  = deq_valid ? pool_q[deq_head] : '0;
    assign deq_fire  = deq_valid && deq_ready;

`ifdef VC_RESERVE_EN
    logic [CNT_W-1:0] empty_others;

    always_comb begin
        empty_others = '0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            if (vc_q[v].count == '0 && VC_W'(v) != enq_vc)
                empty_others = empty_others + 1'b1;
        end
        rsv_ok = free_count > empty_others;
    end
`else
    assign rsv_ok = 1'b1;
`endif

    assign enq_ready = (free_count != '0) && enq_ok && rsv_ok;
    assign enq_fire  = enq_valid && enq_ready;

    // Dequeue is applied first so a same-VC enqueue onto a VC draining its
    // last entry sees an empty list and becomes both head and tail.
    always_comb begin
        vc_d    = vc_q;
        next_we = 1'b0;
        next_wa = '0;
        if (deq_fire) begin
            if (vc_q[deq_sel].count > CNT_W'(1))
                vc_d[deq_sel].head = next_q[deq_head];
            vc_d[deq_sel].count = vc_q[deq_sel].count - 1'b1;
        end
        if (enq_fire) begin
            if (vc_d[enq_sel].count == '0) begin
                vc_d[enq_sel].head = grant_idx;
            end else begin
                next_we = 1'b1;
                next_wa = vc_d[enq_sel].tail;
            end
            vc_d[enq_sel].tail  = grant_idx;
            vc_d[enq_sel].count = vc_d[enq_sel].count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned v = 0; v < NUM_VC; v++) vc_q[v] <= '0;
        end else begin
            vc_q <= vc_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) pool_q[grant_idx] <= enq_data;
        if (next_we)  next_q[next_wa]   <= grant_idx;
    end

    vc_free_list #(
        .DEPTH(DEPTH)
    ) u_free_list (
        .clk        (clk),
        .rst_n      (rst_n),
        .alloc      (enq_fire),
        .rel        (deq_fire),
        .rel_idx    (deq_head),
        .grant_idx  (grant_idx),
        .free_count (free_count)
    );

    int unsigned used_total;

    always_comb begin
        vc_count   = '0;
        used_total = 0;
        for (int unsigned v = 0; v < NUM_VC; v++) begin
            vc_count[v*CNT_W +: CNT_W] = vc_q[v].count;
            used_total = used_total + 32'(vc_q[v].count);
        end
    end

    assert property (@(posedge clk) disable iff (!rst_n)
        used_total + 32'(free_count) == DEPTH);

endmodule
